// File: rtl/custom_reg_bank.sv
// Register-to-hardware bridge: NUM_RW software registers with strobe/ack, NUM_RO sampled status words,
// indexed 1-cycle reads. Optional per-register saturating write counters under CUSTOM_REG_BANK_WCNT_EN.

module custom_reg_bank_rw_lane #(
    parameter int unsigned          REG_WIDTH = 32,
    parameter logic [REG_WIDTH-1:0] RW_RESET  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [REG_WIDTH-1:0] data_i,
    output logic                 ack_o,
    output logic [REG_WIDTH-1:0] q_o
`ifdef CUSTOM_REG_BANK_WCNT_EN
    ,
    output logic [7:0]           cnt_o
`endif
);

    logic [REG_WIDTH-1:0] q_q;
    logic                 ack_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= RW_RESET;
            ack_q <= 1'b0;
        end else begin
            ack_q <= en_i;
            if (en_i) q_q <= data_i;
        end
    end

    assign q_o   = q_q;
    assign ack_o = ack_q;

`ifdef CUSTOM_REG_BANK_WCNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturate at 255 so a long burst never wraps back to a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`endif

endmodule

module custom_reg_bank #(
    parameter int unsigned            REG_WIDTH = 32,
    parameter int unsigned            NUM_RW    = 3,
    parameter int unsigned            NUM_RO    = 3,
    parameter logic [REG_WIDTH-1:0]   RW_RESET  = '0,
    localparam int unsigned           IDX_W     = $clog2(2*NUM_RW+NUM_RO)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_RW*REG_WIDTH-1:0]   reg2ip_data_i,
    input  logic [NUM_RW-1:0]             reg2ip_en_i,
    output logic [NUM_RW-1:0]             reg2ip_ack_o,
    output logic [NUM_RW*REG_WIDTH-1:0]   rw_q_o,
    input  logic [NUM_RO*REG_WIDTH-1:0]   ro_i,
    input  logic                          rd_req_i,
    input  logic [IDX_W-1:0]              rd_idx_i,
    output logic                          rd_valid_o,
    output logic [REG_WIDTH-1:0]          rd_data_o,
    output logic                          rd_err_o
);

    logic [NUM_RW-1:0][REG_WIDTH-1:0] rw_q;
`ifdef CUSTOM_REG_BANK_WCNT_EN
    logic [NUM_RW-1:0][7:0]           wcnt;
`endif

    for (genvar g = 0; g < NUM_RW; g++) begin : g_lane
        custom_reg_bank_rw_lane #(
            .REG_WIDTH (REG_WIDTH),
            .RW_RESET  (RW_RESET)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (reg2ip_en_i[g]),
            .data_i (reg2ip_data_i[g*REG_WIDTH +: REG_WIDTH]),
            .ack_o  (reg2ip_ack_o[g]),
            .q_o    (rw_q[g])
`ifdef CUSTOM_REG_BANK_WCNT_EN
            ,
            .cnt_o  (wcnt[g])
`endif
        );
    end

    assign rw_q_o = rw_q;

    // Read mux sees the registers before this edge's write, giving read-before-write ordering.
    logic [REG_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                 rd_err_d, rd_err_q;
    logic                 rd_valid_q;

    always_comb begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
        for (int i = 0; i < int'(NUM_RW); i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_data_d = rw_q[i];
                rd_err_d  = 1'b0;
            end
        end
        for (int i = 0; i < int'(NUM_RO); i++) begin
            if (rd_idx_i == IDX_W'(int'(NUM_RW) + i)) begin
                rd_data_d = ro_i[i*REG_WIDTH +: REG_WIDTH];
                rd_err_d  = 1'b0;
            end
        end
`ifdef CUSTOM_REG_BANK_WCNT_EN
        for (int i = 0; i < int'(NUM_RW); i++) begin
            if (rd_idx_i == IDX_W'(int'(NUM_RW + NUM_RO) + i)) begin
                rd_data_d = REG_WIDTH'(wcnt[i]);
                rd_err_d  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_data_d;
                rd_err_q  <= rd_err_d;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;

endmodule
